// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with 2-bit direction counters and branch/mispredict counters
module branch_predictor_btb #(
   parameter int         XLEN     = 32,
   parameter int         ENTRIES  = 64,
   parameter int         IDX_W    = $clog2(ENTRIES),
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [XLEN-1:0] lkp_pc_i,
   output logic            pred_taken_o,
   output logic            pred_hit_o,
   output logic [XLEN-1:0] pred_target_o,
   input  logic            upd_valid_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_target_i,
   input  logic            upd_pred_taken_i,
   output logic            mispredict_o,
   output logic [31:0]     branch_cnt_o,
   output logic [31:0]     mispred_cnt_o
);

   localparam int TAG_W = XLEN - IDX_W - 2;

   logic            valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q   [ENTRIES];
   logic [XLEN-1:0] target_q [ENTRIES];
   logic [1:0]      cnt_q    [ENTRIES];

   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0] lkp_idx, upd_idx;
   logic [TAG_W-1:0] lkp_tag, upd_tag;
   logic             upd_en, upd_hit, upd_wr;
   logic [1:0]       upd_cnt_cur, upd_cnt_d;
   logic [XLEN-1:0]  upd_target_d;
   logic             unused_pc_lsbs;

   assign lkp_idx = lkp_pc_i[IDX_W+1:2];
   assign lkp_tag = lkp_pc_i[XLEN-1:IDX_W+2];
   assign upd_idx = upd_pc_i[IDX_W+1:2];
   assign upd_tag = upd_pc_i[XLEN-1:IDX_W+2];
   assign unused_pc_lsbs = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};

   // Lookup reads the registered table only, so a same-cycle update is seen one cycle later.
   assign pred_hit_o    = start_i & valid_q[lkp_idx] & (tag_q[lkp_idx] == lkp_tag);
   assign pred_taken_o  = pred_hit_o & cnt_q[lkp_idx][1];
   assign pred_target_o = pred_hit_o ? target_q[lkp_idx] : '0;

   assign mispredict_o = upd_valid_i & start_i & (upd_taken_i != upd_pred_taken_i);

   assign upd_en      = start_i & upd_valid_i;
   assign upd_hit     = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
   assign upd_cnt_cur = cnt_q[upd_idx];
   assign upd_wr      = upd_en & (upd_hit | upd_taken_i);

   always_comb begin
      upd_cnt_d    = upd_cnt_cur;
      upd_target_d = target_q[upd_idx];
      if (!upd_hit) begin
         upd_cnt_d    = 2'b10;
         upd_target_d = upd_target_i;
      end else if (upd_taken_i) begin
         upd_target_d = upd_target_i;
         if (upd_cnt_cur != 2'b11) begin
            upd_cnt_d = upd_cnt_cur + 2'd1;
         end
      end else if (upd_cnt_cur != 2'b00) begin
         upd_cnt_d = upd_cnt_cur - 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= CNT_INIT;
         end
      end else if (upd_wr) begin
         valid_q[upd_idx] <= 1'b1;
         cnt_q[upd_idx]   <= upd_cnt_d;
      end
   end

   // Tag and target carry no reset; the cleared valid bit masks them.
   always_ff @(posedge clk_i) begin
      if (rst_i && upd_wr) begin
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= upd_target_d;
      end
   end

   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (upd_en) begin
         branch_cnt_d = branch_cnt_q + 32'd1;
      end
      if (mispredict_o) begin
         mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign branch_cnt_o  = branch_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - directed self-checking bench for branch_predictor_btb
module tb_branch_predictor_btb;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] lkp_pc_i;
   logic        pred_taken_o;
   logic        pred_hit_o;
   logic [31:0] pred_target_o;
   logic        upd_valid_i;
   logic [31:0] upd_pc_i;
   logic        upd_taken_i;
   logic [31:0] upd_target_i;
   logic        upd_pred_taken_i;
   logic        mispredict_o;
   logic [31:0] branch_cnt_o;
   logic [31:0] mispred_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_br  = 0;
   logic [31:0] exp_mis = 0;

   branch_predictor_btb dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .lkp_pc_i(lkp_pc_i), .pred_taken_o(pred_taken_o), .pred_hit_o(pred_hit_o),
      .pred_target_o(pred_target_o), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
      .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
      .upd_pred_taken_i(upd_pred_taken_i), .mispredict_o(mispredict_o),
      .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pr);
      upd_valid_i = 1'b1; upd_pc_i = pc; upd_taken_i = tk; upd_target_i = tgt; upd_pred_taken_i = pr;
      @(posedge clk_i); #1;
      upd_valid_i = 1'b0;
      if (start_i && rst_i) begin
         exp_br = exp_br + 1;
         if (tk != pr) exp_mis = exp_mis + 1;
      end
   endtask

   task automatic test_reset;
      rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      lkp_pc_i = 32'h40; #1;
      n_checks++; if (pred_hit_o !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b want 0", pred_hit_o); end
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %0b want 0", pred_taken_o); end
      n_checks++; if (pred_target_o !== 32'h0) begin n_fail++; $display("FAIL reset_target: got %h want 0", pred_target_o); end
      n_checks++; if (branch_cnt_o !== 32'h0) begin n_fail++; $display("FAIL reset_brcnt: got %h want 0", branch_cnt_o); end
      n_checks++; if (mispred_cnt_o !== 32'h0) begin n_fail++; $display("FAIL reset_miscnt: got %h want 0", mispred_cnt_o); end
   endtask

   task automatic test_allocate;
      upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h20; upd_pred_taken_i = 1'b0;
      #1;
      n_checks++; if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL alloc_mispredict: got %0b want 1", mispredict_o); end
      @(posedge clk_i); #1;
      upd_valid_i = 1'b0; exp_br = exp_br + 1; exp_mis = exp_mis + 1;
      lkp_pc_i = 32'h40; #1;
      n_checks++; if (pred_hit_o !== 1'b1) begin n_fail++; $display("FAIL alloc_hit: got %0b want 1", pred_hit_o); end
      n_checks++; if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL alloc_taken: got %0b want 1", pred_taken_o); end
      n_checks++; if (pred_target_o !== 32'h20) begin n_fail++; $display("FAIL alloc_target: got %h want 20", pred_target_o); end
      n_checks++; if (branch_cnt_o !== 32'd1) begin n_fail++; $display("FAIL alloc_brcnt: got %0d want 1", branch_cnt_o); end
      n_checks++; if (mispred_cnt_o !== 32'd1) begin n_fail++; $display("FAIL alloc_miscnt: got %0d want 1", mispred_cnt_o); end
   endtask

   task automatic test_counter;
      // 10 -> 01 -> 00 -> 00 (saturate low)
      upd(32'h40, 1'b0, 32'h0, 1'b1);
      upd(32'h40, 1'b0, 32'h0, 1'b0);
      upd(32'h40, 1'b0, 32'h0, 1'b0);
      lkp_pc_i = 32'h40; #1;
      n_checks++; if (pred_hit_o !== 1'b1) begin n_fail++; $display("FAIL cnt_low_hit: got %0b want 1", pred_hit_o); end
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL cnt_low_taken: got %0b want 0", pred_taken_o); end
      n_checks++; if (pred_target_o !== 32'h20) begin n_fail++; $display("FAIL cnt_low_target: got %h want 20", pred_target_o); end
      upd(32'h40, 1'b1, 32'h20, 1'b0);
      upd(32'h40, 1'b1, 32'h20, 1'b0);
      #1;
      n_checks++; if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL cnt_two_taken: got %0b want 1", pred_taken_o); end
      upd(32'h40, 1'b1, 32'h20, 1'b1);
      upd(32'h40, 1'b1, 32'h20, 1'b1);
      upd(32'h40, 1'b0, 32'h0, 1'b1);
      #1;
      n_checks++; if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL cnt_sat_high: got %0b want 1", pred_taken_o); end
      n_checks++; if (branch_cnt_o !== exp_br) begin n_fail++; $display("FAIL cnt_brcnt: got %0d want %0d", branch_cnt_o, exp_br); end
      n_checks++; if (mispred_cnt_o !== exp_mis) begin n_fail++; $display("FAIL cnt_miscnt: got %0d want %0d", mispred_cnt_o, exp_mis); end
   endtask

   task automatic test_alias;
      lkp_pc_i = 32'h140; #1;
      n_checks++; if (pred_hit_o !== 1'b0) begin n_fail++; $display("FAIL alias_miss: got %0b want 0", pred_hit_o); end
      upd(32'h140, 1'b0, 32'h0, 1'b0);
      lkp_pc_i = 32'h40; #1;
      n_checks++; if ({pred_hit_o, pred_taken_o} !== 2'b11 || pred_target_o !== 32'h20) begin
         n_fail++; $display("FAIL alias_nt_keep: got hit=%0b tk=%0b tgt=%h want 1 1 20", pred_hit_o, pred_taken_o, pred_target_o);
      end
      upd(32'h140, 1'b1, 32'h80, 1'b0);
      lkp_pc_i = 32'h40; #1;
      n_checks++; if (pred_hit_o !== 1'b0) begin n_fail++; $display("FAIL alias_evict: got %0b want 0", pred_hit_o); end
      lkp_pc_i = 32'h140; #1;
      n_checks++; if ({pred_hit_o, pred_taken_o} !== 2'b11 || pred_target_o !== 32'h80) begin
         n_fail++; $display("FAIL alias_alloc: got hit=%0b tk=%0b tgt=%h want 1 1 80", pred_hit_o, pred_taken_o, pred_target_o);
      end
      // Freshly allocated at 10: one not-taken drops it below the taken threshold.
      upd(32'h140, 1'b0, 32'h0, 1'b1);
      #1;
      n_checks++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL alias_cnt10: got %0b want 0", pred_taken_o); end
   endtask

   task automatic test_same_cycle;
      upd(32'h40, 1'b1, 32'h20, 1'b0);
      upd(32'h40, 1'b0, 32'h0, 1'b1);
      lkp_pc_i = 32'h40;
      upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h24; upd_pred_taken_i = 1'b0;
      #1;
      n_checks++; if ({pred_hit_o, pred_taken_o} !== 2'b10 || pred_target_o !== 32'h20) begin
         n_fail++; $display("FAIL same_pre: got hit=%0b tk=%0b tgt=%h want 1 0 20", pred_hit_o, pred_taken_o, pred_target_o);
      end
      @(posedge clk_i); #1;
      upd_valid_i = 1'b0; exp_br = exp_br + 1; exp_mis = exp_mis + 1;
      #1;
      n_checks++; if ({pred_hit_o, pred_taken_o} !== 2'b11 || pred_target_o !== 32'h24) begin
         n_fail++; $display("FAIL same_post: got hit=%0b tk=%0b tgt=%h want 1 1 24", pred_hit_o, pred_taken_o, pred_target_o);
      end
      n_checks++; if (branch_cnt_o !== exp_br) begin n_fail++; $display("FAIL same_brcnt: got %0d want %0d", branch_cnt_o, exp_br); end
   endtask

   task automatic test_wrap;
      force dut.branch_cnt_q = 32'hFFFF_FFFF;
      #1 release dut.branch_cnt_q;
      #1;
      n_checks++; if (branch_cnt_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", branch_cnt_o); end
      upd(32'h40, 1'b1, 32'h24, 1'b1);
      n_checks++; if (branch_cnt_o !== 32'h0) begin n_fail++; $display("FAIL wrap_brcnt: got %h want 0", branch_cnt_o); end
      n_checks++; if (mispred_cnt_o !== exp_mis) begin n_fail++; $display("FAIL wrap_miscnt: got %0d want %0d", mispred_cnt_o, exp_mis); end
      exp_br = 32'h0;
   endtask

   task automatic test_reset_with_update;
      rst_i = 1'b0;
      upd_valid_i = 1'b1; upd_pc_i = 32'h80; upd_taken_i = 1'b1; upd_target_i = 32'h100; upd_pred_taken_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1; upd_valid_i = 1'b0; exp_br = 0; exp_mis = 0;
      lkp_pc_i = 32'h80; #1;
      n_checks++; if (pred_hit_o !== 1'b0) begin n_fail++; $display("FAIL rstupd_noalloc: got %0b want 0", pred_hit_o); end
      lkp_pc_i = 32'h40; #1;
      n_checks++; if (pred_hit_o !== 1'b0) begin n_fail++; $display("FAIL rstupd_cleared: got %0b want 0", pred_hit_o); end
      n_checks++; if (branch_cnt_o !== 32'h0 || mispred_cnt_o !== 32'h0) begin
         n_fail++; $display("FAIL rstupd_counters: got %h %h want 0 0", branch_cnt_o, mispred_cnt_o);
      end
   endtask

   task automatic test_start_low;
      upd(32'h40, 1'b1, 32'h20, 1'b0);
      start_i = 1'b0;
      lkp_pc_i = 32'h40;
      upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b0; upd_target_i = 32'h0; upd_pred_taken_i = 1'b1;
      #1;
      n_checks++; if ({pred_hit_o, pred_taken_o, mispredict_o} !== 3'b000 || pred_target_o !== 32'h0) begin
         n_fail++; $display("FAIL stop_outputs: got hit=%0b tk=%0b mis=%0b tgt=%h want 0 0 0 0", pred_hit_o, pred_taken_o, mispredict_o, pred_target_o);
      end
      @(posedge clk_i); #1;
      upd_valid_i = 1'b0;
      start_i = 1'b1; #1;
      n_checks++; if ({pred_hit_o, pred_taken_o} !== 2'b11 || pred_target_o !== 32'h20) begin
         n_fail++; $display("FAIL stop_table_held: got hit=%0b tk=%0b tgt=%h want 1 1 20", pred_hit_o, pred_taken_o, pred_target_o);
      end
      n_checks++; if (branch_cnt_o !== exp_br || mispred_cnt_o !== exp_mis) begin
         n_fail++; $display("FAIL stop_counters: got %0d %0d want %0d %0d", branch_cnt_o, mispred_cnt_o, exp_br, exp_mis);
      end
   endtask

   initial begin
      rst_i = 1'b0; start_i = 1'b1; lkp_pc_i = '0;
      upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0; upd_pred_taken_i = 1'b0;
      test_reset;
      test_allocate;
      test_counter;
      test_alias;
      test_same_cycle;
      test_wrap;
      test_reset_with_update;
      test_start_low;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
